// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path.
package spi_pkg;

  localparam int unsigned SPI_WIDTH_DEF = 16;
  localparam int unsigned BIT_CNT_W     = 5;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// DEPTH-entry output FIFO for received words; the head is held in a register so
// dout is stable while the consumer stalls. Used only when SPI_RX_FIFO_EN is defined.
module spi_rx_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_c,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, remain_c;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d, overflow_q, overflow_d;
  logic             pop_c, full_c, wr_en_c;

  // A push into a full FIFO still succeeds when the head is popped in the same cycle.
  always_comb begin
    pop_c      = valid_q & ready;
    full_c     = (count_q == CW'(DEPTH));
    wr_en_c    = push_c & (~full_c | pop_c);
    overflow_d = push_c & full_c & ~pop_c;
    wr_ptr_d   = wr_en_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    remain_c   = count_q - CW'(pop_c);
    count_d    = remain_c + CW'(wr_en_c);
    valid_d    = (count_d != '0);
    if (remain_c != '0) begin
      dout_d = mem_q[rd_ptr_d];
    end else if (wr_en_c) begin
      dout_d = din;
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign dout     = dout_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver: synchronizes the serial inputs, assembles MSB-first frames and
// buffers complete words. Define SPI_RX_FIFO_EN for a DEPTH-entry FIFO, else one holding register.
module spi_rx
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_cs_l,
  input  logic                 spi_clk,
  input  logic                 spi_data,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_err,
  output logic                 overflow,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  logic [1:0]           cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, data_sync_q, data_sync_d;
  logic                 sclk_prev_q, sclk_prev_d;
  logic                 cs_s, sclk_s, data_s, sclk_rise;
  spi_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push_c;

  // Two-flop synchronizers and spi_clk rising-edge detect.
  always_comb begin
    cs_sync_d   = {cs_sync_q[0], spi_cs_l};
    sclk_sync_d = {sclk_sync_q[0], spi_clk};
    data_sync_d = {data_sync_q[0], spi_data};
    cs_s        = cs_sync_q[1];
    sclk_s      = sclk_sync_q[1];
    data_s      = data_sync_q[1];
    sclk_prev_d = sclk_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[WIDTH-2:0], data_s};
          if (bit_cnt_q != BIT_CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        if (cs_s) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (bit_cnt_q == BIT_CNT_W'(WIDTH)) begin
          push_c = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= 2'b11;
      sclk_sync_q <= 2'b00;
      data_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      data_sync_q <= data_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bit_cnt   = bit_cnt_q;
  assign frame_err = frame_err_q;

`ifdef SPI_RX_FIFO_EN
  spi_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_c   (push_c),
    .din      (shreg_q),
    .ready    (dout_ready),
    .dout     (dout),
    .valid    (dout_valid),
    .overflow (overflow)
  );
`else
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d, ovf_q, ovf_d;
  logic             pop_c, accept_c;
  logic             unused_depth_c;

  // Single holding register; a push is accepted when empty or popped in the same cycle.
  always_comb begin
    pop_c      = hold_vld_q & dout_ready;
    accept_c   = push_c & (~hold_vld_q | pop_c);
    ovf_d      = push_c & hold_vld_q & ~pop_c;
    hold_vld_d = accept_c | (hold_vld_q & ~pop_c);
    hold_d     = accept_c ? shreg_q : hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  // DEPTH only sizes the FIFO build.
  assign unused_depth_c = ^DEPTH;
  assign dout           = hold_q;
  assign dout_valid     = hold_vld_q;
  assign overflow       = ovf_q;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx; expectations adapt to SPI_RX_FIFO_EN (4-entry FIFO or
// single holding register).
module tb_spi_rx;

  localparam int unsigned WIDTH = 16;
`ifdef SPI_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n, spi_cs_l, spi_clk, spi_data, dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid, frame_err, overflow;
  logic [4:0]       bit_cnt;

  int n_cmp = 0, n_bad = 0;
  int n_ferr = 0, n_ovf = 0, n_vcyc = 0;
  int f0, o0, v0;
  logic [WIDTH-1:0] pops[$];
  logic [WIDTH-1:0] words[5] = '{16'h2563, 16'h9B63, 16'h6A61, 16'hA265, 16'h7564};

  spi_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_cs_l   (spi_cs_l),
    .spi_clk    (spi_clk),
    .spi_data   (spi_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters and record of every word accepted by the consumer.
  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
    if (dout_valid) n_vcyc++;
    if (dout_valid && dout_ready) pops.push_back(dout);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_clk  = 1'b0;
      spi_data = w[i];
      tick(5);
      spi_clk = 1'b1;
      tick(5);
    end
    spi_clk = 1'b0;
  endtask

  // pop_at_push raises dout_ready for exactly the cycle the frame's word is pushed.
  task automatic send_frame(input logic [31:0] w, input int n, input bit pop_at_push);
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(w, n);
    tick(4);
    spi_cs_l = 1'b1;
    if (pop_at_push) begin
      tick(3);
      dout_ready = 1'b1;
      tick(1);
      dout_ready = 1'b0;
    end
    tick(10);
  endtask

  initial begin
    reset_n    = 1'b0;
    spi_cs_l   = 1'b1;
    spi_clk    = 1'b0;
    spi_data   = 1'b0;
    dout_ready = 1'b0;
    tick(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_valid", 32'(dout_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_bitcnt", 32'(bit_cnt), 32'h0);
    reset_n = 1'b1;
    tick(3);

    // Single frame, consumer always ready.
    dout_ready = 1'b1;
    f0 = n_ferr; o0 = n_ovf; v0 = n_vcyc;
    pops.delete();
    send_frame(32'hA569, 16, 1'b0);
    check("t1_bitcnt", 32'(bit_cnt), 32'd16);
    check("t1_npop", 32'(pops.size()), 32'd1);
    check("t1_word", 32'(pops[0]), 32'hA569);
    check("t1_vcyc", 32'(n_vcyc - v0), 32'd1);
    check("t1_ferr", 32'(n_ferr - f0), 32'd0);
    check("t1_ovf", 32'(n_ovf - o0), 32'd0);

    // Back-to-back frames with a stalled consumer, then one more to overflow.
    dout_ready = 1'b0;
    o0 = n_ovf;
    pops.delete();
    for (int i = 0; i < 4; i++) send_frame(32'(words[i]), 16, 1'b0);
    check("t2_head4", 32'(dout), 32'h2563);
    check("t2_valid4", 32'(dout_valid), 32'd1);
    check("t2_ovf4", 32'(n_ovf - o0), 32'(4 - CAP));
    send_frame(32'(words[4]), 16, 1'b0);
    check("t2_ovf5", 32'(n_ovf - o0), 32'(5 - CAP));
    check("t2_head5", 32'(dout), 32'h2563);
    dout_ready = 1'b1;
    tick(8);
    dout_ready = 1'b0;
    check("t2_npop", 32'(pops.size()), 32'(CAP));
    for (int i = 0; i < CAP; i++) check($sformatf("t2_pop%0d", i), 32'(pops[i]), 32'(words[i]));
    check("t2_empty", 32'(dout_valid), 32'd0);

    // Short frame of 9 bits, then a good frame.
    dout_ready = 1'b1;
    f0 = n_ferr;
    pops.delete();
    send_frame(32'h1A5, 9, 1'b0);
    check("t3_ferr", 32'(n_ferr - f0), 32'd1);
    check("t3_nopop", 32'(pops.size()), 32'd0);
    send_frame(32'(words[1]), 16, 1'b0);
    check("t3_npop", 32'(pops.size()), 32'd1);
    check("t3_word", 32'(pops[0]), 32'h9B63);
    check("t3_ferr2", 32'(n_ferr - f0), 32'd1);

    // Long frame of 20 bits.
    f0 = n_ferr;
    pops.delete();
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(32'hABCDE, 20);
    tick(4);
    check("t4_bitcnt", 32'(bit_cnt), 32'd20);
    spi_cs_l = 1'b1;
    tick(10);
    check("t4_ferr", 32'(n_ferr - f0), 32'd1);
    check("t4_nopop", 32'(pops.size()), 32'd0);

    // Reset in the middle of a frame.
    pops.delete();
    spi_cs_l = 1'b0;
    tick(4);
    send_bits(32'hA2, 8);
    tick(2);
    check("t5_bitcnt_pre", 32'(bit_cnt), 32'd8);
    reset_n = 1'b0;
    #1;
    check("t5_dout", 32'(dout), 32'h0);
    check("t5_valid", 32'(dout_valid), 32'h0);
    check("t5_bitcnt", 32'(bit_cnt), 32'h0);
    check("t5_ferr_lvl", 32'(frame_err), 32'h0);
    check("t5_ovf_lvl", 32'(overflow), 32'h0);
    spi_cs_l = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    f0 = n_ferr;
    send_frame(32'(words[4]), 16, 1'b0);
    check("t5_npop", 32'(pops.size()), 32'd1);
    check("t5_word", 32'(pops[0]), 32'h7564);
    check("t5_ferr", 32'(n_ferr - f0), 32'd0);

    // Buffer full, pop coincides with push: no overflow.
    dout_ready = 1'b0;
    o0 = n_ovf; f0 = n_ferr;
    pops.delete();
    for (int i = 0; i < CAP; i++) send_frame(32'(words[i]), 16, 1'b0);
    check("t6_valid", 32'(dout_valid), 32'd1);
    send_frame(32'(words[4]), 16, 1'b1);
    check("t6_ovf", 32'(n_ovf - o0), 32'd0);
    check("t6_npop1", 32'(pops.size()), 32'd1);
    check("t6_pop0", 32'(pops[0]), 32'h2563);
    check("t6_ferr", 32'(n_ferr - f0), 32'd0);
    dout_ready = 1'b1;
    tick(8);
    dout_ready = 1'b0;
    check("t6_npop", 32'(pops.size()), 32'(CAP + 1));
    for (int i = 1; i < CAP; i++) check($sformatf("t6_pop%0d", i), 32'(pops[i]), 32'(words[i]));
    check("t6_last", 32'(pops[CAP]), 32'h7564);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, frame length in bits.
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port spi_cs_l  input  1  chip select from upstream SPI master, active-low.
REQ-006 SHALL have port spi_clk  input  1  serial clock from master, asynchronous to clk.
REQ-007 SHALL have port spi_data  input  1  serial data, MSB first.
REQ-008 SHALL have port dout  output  WIDTH  received word at FIFO head.
REQ-009 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: bad frame length.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse: complete word dropped, FIFO full.
REQ-013 SHALL have port bit_cnt  output  5  bits received in current frame.

Function
REQ-014 SHALL pass spi_cs_l, spi_clk and spi_data through two-flop synchronizers before use.
REQ-015 SHALL detect spi_clk rising edges on the synchronized signal; spi_clk high and low phases each >=2 clk periods.
REQ-016 SHALL use FSM states IDLE, SHIFT, CHECK.
REQ-017 IDLE -> SHIFT when synchronized spi_cs_l is low; bit_cnt and shift register are cleared on entry.
REQ-018 In SHIFT, each detected spi_clk rising edge SHALL shift synchronized spi_data into the LSB and increment bit_cnt, saturating at 31.
REQ-019 SHIFT -> CHECK when synchronized spi_cs_l returns high.
REQ-020 In CHECK, if bit_cnt == WIDTH the word SHALL be pushed to the FIFO; otherwise frame_err SHALL pulse and the word SHALL be discarded; CHECK -> IDLE always, after one cycle.
REQ-021 Push when full SHALL drop the new word, keep FIFO contents and pulse overflow.
REQ-022 Handshake: pop occurs when dout_valid and dout_ready are both high; dout SHALL hold steady while dout_valid is high and dout_ready is low.
REQ-023 Simultaneous push and pop when full SHALL succeed with no overflow.
REQ-024 Pushed word SHALL appear on dout with dout_valid high the cycle after the CHECK cycle when the FIFO was empty.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits wide.

Reset
REQ-026 reset_n low SHALL force IDLE, empty FIFO, bit_cnt=0, dout=0, dout_valid=0, frame_err=0, overflow=0 and clear synchronizers to cs high, clk low, data low.
REQ-027 Reset mid-frame SHALL discard the partial word; after release the FSM SHALL wait in IDLE for the next spi_cs_l falling edge.

Configuration
REQ-028 With SPI_RX_FIFO_EN defined, output buffering SHALL be the DEPTH-entry FIFO.
REQ-029 Without SPI_RX_FIFO_EN, output buffering SHALL be a single holding register (effective depth 1); DEPTH is ignored; overflow is raised when the register is valid and not popped in the push cycle.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state enum (IDLE, SHIFT, CHECK) and the default frame width constant 16.
REQ-031 FIFO SHALL be sub-module spi_rx_fifo (WIDTH, DEPTH), instantiated only under SPI_RX_FIFO_EN.

Verification
REQ-032 Frame 16'hA569, spi_clk period 10 clk, dout_ready=1 -> dout=16'hA569, dout_valid for one cycle, frame_err=0.
REQ-033 Frames 16'h2563, 16'h9B63, 16'h6A61, 16'hA265 back-to-back with dout_ready=0 -> four words held in order; fifth frame 16'h7564 -> overflow pulse; head stays 16'h2563.
REQ-034 cs_l released after 9 bits -> frame_err pulse, no dout_valid; next full frame 16'h9B63 is received correctly.
REQ-035 20 clock edges within one cs_l low window -> frame_err pulse, bit_cnt=20 before CHECK, no push.
REQ-036 reset_n asserted after 8 bits of 16'hA265 -> all outputs 0 immediately; following frame 16'h7564 -> dout=16'h7564.
REQ-037 FIFO full with dout_ready=1 in the push cycle -> push and pop both occur, no overflow pulse; repeat without SPI_RX_FIFO_EN.
